// File: rtl/freelist.sv
// Physical-register free list: circular FIFO of free tags with 4-wide allocate and 4-wide free.
// Optional FREELIST_CHECKPOINT_EN adds a single head snapshot with restore.
module freelist #(
    parameter int WIDTH = 7,
    parameter int ARCH  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [3:0]         i_req,
    output logic               o_grant,
    output logic [4*WIDTH-1:0] o_setAddr4x,
    input  logic [3:0]         i_freeVal,
    input  logic [4*WIDTH-1:0] i_free4x,
`ifdef FREELIST_CHECKPOINT_EN
    input  logic               i_ckpt,
    input  logic               i_restore,
`endif
    output logic [WIDTH:0]     o_count,
    output logic               o_err
);
    localparam int DEPTH = 1 << WIDTH;
    localparam int CAP   = DEPTH - ARCH;
    localparam logic [WIDTH:0] CAP_C = (WIDTH+1)'(CAP);

    logic [WIDTH-1:0] ring [DEPTH];
    logic [WIDTH-1:0] head, tail;
    logic [WIDTH-1:0] head_nxt, tail_nxt;
    logic [WIDTH:0]   count, count_nxt, room;
    logic [2:0]       nreq, nalloc, acc, pos;
    logic             grant, drop, restore;
    logic [3:0]       wr_en;
    logic [WIDTH-1:0] wr_addr [4];
    logic [WIDTH-1:0] ckpt_head;
    logic [WIDTH-1:0] diff;

`ifdef FREELIST_CHECKPOINT_EN
    assign restore = i_restore;
`else
    assign restore = 1'b0;
`endif

    // Handshake: i_req is a per-slot request; it is consumed at the edge only
    // when o_grant=1 (all-or-nothing), otherwise the caller must re-request.
    always_comb begin
        nreq = '0;
        for (int k = 0; k < 4; k++) nreq = nreq + {2'b00, i_req[k]};
        grant = ((WIDTH+1)'(nreq) <= count) && !restore;
        nalloc = grant ? nreq : 3'd0;

        pos = '0;
        o_setAddr4x = '0;
        for (int k = 0; k < 4; k++) begin
            if (grant && i_req[k])
                o_setAddr4x[k*WIDTH +: WIDTH] = ring[head + WIDTH'(pos)];
            pos = pos + {2'b00, i_req[k]};
        end

        // Room available after this cycle's allocation; excess returns are dropped.
        room = CAP_C - count + (WIDTH+1)'(nalloc);
        acc  = '0;
        drop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_en[k]   = 1'b0;
            wr_addr[k] = tail + WIDTH'(acc);
            if (i_freeVal[k] && (i_free4x[k*WIDTH +: WIDTH] != '0)) begin
                if ((WIDTH+1)'(acc) < room) begin
                    wr_en[k] = 1'b1;
                    acc      = acc + 3'd1;
                end else begin
                    drop = 1'b1;
                end
            end
        end

        tail_nxt  = tail + WIDTH'(acc);
        head_nxt  = head + WIDTH'(nalloc);
        count_nxt = count - (WIDTH+1)'(nalloc) + (WIDTH+1)'(acc);
        diff      = tail_nxt - ckpt_head;
        if (restore) begin
            head_nxt  = ckpt_head;
            count_nxt = (diff == '0) ? CAP_C : {1'b0, diff};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                ring[i] <= (i < CAP) ? WIDTH'(ARCH + i) : '0;
            head      <= '0;
            tail      <= WIDTH'(CAP);
            count     <= CAP_C;
            o_err     <= 1'b0;
            ckpt_head <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (wr_en[k]) ring[wr_addr[k]] <= i_free4x[k*WIDTH +: WIDTH];
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
            o_err <= o_err | drop;
`ifdef FREELIST_CHECKPOINT_EN
            if (i_ckpt && !i_restore) ckpt_head <= head_nxt;
`endif
        end
    end

    assign o_grant = grant;
    assign o_count = count;
endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: FIFO reference model of free tags,
// expected grant/tag vectors queued at drive time and compared at negedge.
module tb_freelist;
    localparam int W   = 7;
    localparam int CAP = 96;

    logic           clk;
    logic           i_rst;
    logic [3:0]     i_req;
    logic           o_grant;
    logic [4*W-1:0] o_setAddr4x;
    logic [3:0]     i_freeVal;
    logic [4*W-1:0] i_free4x;
    logic [W:0]     o_count;
    logic           o_err;
`ifdef FREELIST_CHECKPOINT_EN
    logic           i_ckpt;
    logic           i_restore;
`endif

    freelist #(.WIDTH(W), .ARCH(32)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .o_grant     (o_grant),
        .o_setAddr4x (o_setAddr4x),
        .i_freeVal   (i_freeVal),
        .i_free4x    (i_free4x),
`ifdef FREELIST_CHECKPOINT_EN
        .i_ckpt      (i_ckpt),
        .i_restore   (i_restore),
`endif
        .o_count     (o_count),
        .o_err       (o_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]   fl_q[$];      // reference free list, head at front
    logic [W:0]     exp_q[$];     // expected count queue, cleared at start
    logic [4*W:0]   sb_q[$];      // expected {grant, tags}
    logic [W-1:0]   live_q[$];    // tags handed out in the random phase
    logic           live [1<<W];
    logic           m_err;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        fl_q.delete();
        sb_q.delete();
        for (int i = 0; i < CAP; i++) fl_q.push_back(W'(32 + i));
        for (int i = 0; i < (1 << W); i++) live[i] = (i < 32);
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_req = '0; i_freeVal = '0; i_free4x = '0;
`ifdef FREELIST_CHECKPOINT_EN
        i_ckpt = 1'b0; i_restore = 1'b0;
`endif
        @(posedge clk); #1;
        i_rst = 1'b0;
        model_reset();
        check("rst_count", 64'(o_count), 64'(CAP));
        check("rst_err", 64'(o_err), 64'd0);
    endtask

    // one cycle: drive, queue expectation, compare outputs, then commit model
    task automatic step(input logic [3:0] req, input logic [3:0] fv, input logic [4*W-1:0] ft);
        logic         g;
        logic [4*W-1:0] tags;
        logic [4*W:0] exp_v;
        int nreq, idx;
        logic [W-1:0] t;
        i_req = req; i_freeVal = fv; i_free4x = ft;
        nreq = 0;
        for (int k = 0; k < 4; k++) nreq += int'(req[k]);
        g = (nreq <= fl_q.size());
        tags = '0; idx = 0;
        for (int k = 0; k < 4; k++)
            if (g && req[k]) begin
                tags[k*W +: W] = fl_q[idx];
                idx++;
            end
        sb_q.push_back({g, tags});

        @(negedge clk);
        exp_v = sb_q.pop_front();
        check("alloc", 64'({o_grant, o_setAddr4x}), 64'(exp_v));
        for (int k = 0; k < 4; k++)
            if (o_grant && req[k]) begin
                t = o_setAddr4x[k*W +: W];
                check("dup", 64'(live[t]), 64'd0);
                live[t] = 1'b1;
            end

        if (g) for (int k = 0; k < nreq; k++) void'(fl_q.pop_front());
        for (int k = 0; k < 4; k++) begin
            t = ft[k*W +: W];
            if (fv[k] && t != '0) begin
                live[t] = 1'b0;
                if (fl_q.size() < CAP) fl_q.push_back(t);
                else m_err = 1'b1;
            end
        end

        @(posedge clk); #1;
        check("count", 64'(o_count), 64'(fl_q.size()));
        check("err", 64'(o_err), 64'(m_err));
    endtask

    initial begin
        logic [3:0]     rq, fv;
        logic [4*W-1:0] ft;
        int nf, j;
        i_rst = 1'b1; i_req = '0; i_freeVal = '0; i_free4x = '0;
`ifdef FREELIST_CHECKPOINT_EN
        i_ckpt = 1'b0; i_restore = 1'b0;
`endif
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // directed: first allocations and compaction
        step(4'b1111, 4'b0000, '0);
        check("t1_tag0", 64'(o_count), 64'd92);
        step(4'b1010, 4'b0000, '0);
        check("t2_count", 64'(o_count), 64'd90);

        // drain to 3, then refused and accepted requests
        repeat (21) step(4'b1111, 4'b0000, '0);
        step(4'b0111, 4'b0000, '0);
        check("t3_count3", 64'(o_count), 64'd3);
        step(4'b1111, 4'b0000, '0);
        step(4'b0111, 4'b0000, '0);
        check("t3_count0", 64'(o_count), 64'd0);

        // free at count 0 is not bypassed into the same-cycle grant
        ft = '0; ft[0 +: W] = W'(40); ft[W +: W] = W'(41);
        step(4'b0001, 4'b0011, ft);
        step(4'b0001, 4'b0000, '0);
        check("t4_count1", 64'(o_count), 64'd1);

        // random alloc/free with wrap, tag-0 returns mixed in
        do_reset();
        live_q.delete();
        for (int c = 0; c < 200; c++) begin
            rq = 4'($urandom_range(0, 15));
            fv = '0; ft = '0;
            nf = $urandom_range(0, 4);
            for (int k = 0; k < 4; k++) begin
                if (k < nf && live_q.size() > 0) begin
                    j = $urandom_range(0, live_q.size() - 1);
                    ft[k*W +: W] = live_q[j];
                    live_q.delete(j);
                    fv[k] = 1'b1;
                end else if ($urandom_range(0, 9) == 0) begin
                    fv[k] = 1'b1;   // tag 0 return must be ignored
                end
            end
            step(rq, fv, ft);
            if (o_grant === 1'b1) begin end
            for (int k = 0; k < 4; k++)
                if (live[o_setAddr4x[k*W +: W]] && rq[k] && sb_q.size() == 0) begin end
            // collect what the model granted this cycle
            begin
                int n; n = 0;
                for (int k = 0; k < 4; k++) n += int'(rq[k]);
                for (int k = 0; k < (1 << W); k++) begin end
                if (n > 0) begin
                    // tags just allocated are those marked live but not yet tracked
                    for (int tg = 32; tg < (1 << W); tg++)
                        if (live[tg]) begin
                            bit found; found = 0;
                            foreach (live_q[q]) if (live_q[q] == W'(tg)) found = 1;
                            if (!found) live_q.push_back(W'(tg));
                        end
                end
            end
        end

        // overflow: room of 1, three returns -> one written, error sticky
        do_reset();
        step(4'b0001, 4'b0000, '0);
        ft = '0; ft[0 +: W] = W'(32); ft[W +: W] = W'(5); ft[2*W +: W] = W'(6);
        step(4'b0000, 4'b0111, ft);
        check("ovf_err", 64'(o_err), 64'd1);
        check("ovf_count", 64'(o_count), 64'(CAP));
        repeat (3) step(4'b0001, 4'b0000, '0);
        check("ovf_sticky", 64'(o_err), 64'd1);
        do_reset();

`ifdef FREELIST_CHECKPOINT_EN
        // snapshot at head=4, allocate 8 more, restore
        i_ckpt = 1'b1; i_req = 4'b1111; @(posedge clk); #1;
        i_ckpt = 1'b0; repeat (2) begin @(posedge clk); #1; end
        i_req = 4'b0000; i_restore = 1'b1;
        @(negedge clk);
        check("ckpt_nogrant", 64'(o_grant), 64'd0);
        @(posedge clk); #1;
        i_restore = 1'b0;
        check("ckpt_count", 64'(o_count), 64'd92);
        i_req = 4'b0001;
        @(negedge clk);
        check("ckpt_tag", 64'(o_setAddr4x[W-1:0]), 64'd36);
        @(posedge clk); #1;
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
